data_memory_controller: RTL and testbench
=========================================

Name: data_memory_controller

Overview:
Byte-addressable data memory with load/store controller for the MEM stage of the pipelined RISC-V core. Performs byte, halfword and word stores and loads, little-endian, with sign or zero extension on loads. Every access takes two cycles and raises a stall to freeze the pipeline for the first cycle. Exposes word 1 of memory as a debug output.

Parameters:
ADDR_WIDTH, 32, width of mem_addr
DATA_WIDTH, 32, width of write/read data (must be 32)
NUM_MEM_BYTES, 256, memory size in bytes; power of two, multiple of 4

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset, asynchronous, active-high (asserted = 1)
mem_addr  in  ADDR_WIDTH  byte address
mem_write_data  in  DATA_WIDTH  store data; low bits used for byte/half
mem_read  in  1  load request
mem_write  in  1  store request
load_store_type  in  2  access size: LS_BYTE / LS_HALF / LS_WORD
load_unsigned  in  1  1 = zero-extend load, 0 = sign-extend
mem_read_data  out  DATA_WIDTH  extended load result
mem1  out  32  debug: memory word at byte address 4..7
stall  out  1  pipeline freeze request

Behaviour:
- Storage: NUM_MEM_BYTES bytes, organised as NUM_MEM_BYTES/4 words of 4 byte lanes. Little-endian: byte at address 4k+i sits in word k, bits 8i+7:8i.
- Address use: word index = mem_addr[log2(NUM_MEM_BYTES)-1:2]; upper bits ignored, so addresses wrap modulo NUM_MEM_BYTES. Byte offset = mem_addr[1:0].
- Alignment: half uses mem_addr[1] only (bit 0 ignored). Word ignores mem_addr[1:0]. No misalignment trap.
- Reset (rstn=1, async): all memory bytes = 0, FSM = IDLE, registered read word = 0. Outputs: mem_read_data = 0, stall = 0, mem1 = 0.
- FSM states IDLE, ACCESS:
  - IDLE: if mem_read or mem_write, stall = 1 (combinational) and next state = ACCESS. Otherwise stall = 0 and state stays IDLE.
  - ACCESS: stall = 0. At the clock edge ending ACCESS, the store is committed or the addressed word is registered; next state = IDLE.
  - A request held high starts a new two-cycle access each time.
  - A request deasserted during ACCESS aborts it: no commit, back to IDLE.
- Store: byte writes lane mem_addr[1:0] with data[7:0]. Half writes lanes {2*addr[1]+1, 2*addr[1]} with data[15:0]. Word writes all lanes. Other lanes are unchanged.
- Load: the registered raw word is selected and extended combinationally from the current mem_addr[1:0], load_store_type and load_unsigned.
  - Byte: the lane byte, sign- or zero-extended to 32 bits.
  - Half: the selected half, sign- or zero-extended to 32 bits.
  - Word: the raw word; load_unsigned is ignored.
  - Changing load_unsigned or the offset changes mem_read_data in the same cycle, with no new access.
- mem_read_data holds its last value when no read completes.
- mem_read and mem_write together: write has priority, and the registered read word is not updated.
- load_store_type = 2'b11 is treated as LS_WORD.
- mem1: combinational view of memory word 1 (bytes 4..7), reflecting commits the cycle after the edge.

Decomposition:
- Shared package: LS_BYTE = 2'b00, LS_HALF = 2'b01, LS_WORD = 2'b10, and the FSM state enum. The codebase currently uses controls.sv defines; package constants must match those values.
- Sub-module load_extender (combinational): raw word, offset, type, unsigned in; 32-bit result out.

Test Plan:
- Byte store 0xF0F0F0F0 at addr 22 (5<<2|2), held 2 cycles -> stall = 1 on first cycle, 0 on second. Byte load from 22 signed -> 0xFFFFFFF0. Raise load_unsigned -> 0x000000F0 in the same cycle.
- Half store 0xF0F0F0F0 at addr 150, then half load -> signed 0xFFFFF0F0, unsigned 0x0000F0F0.
- Word store 0xF0F0F0F0 at addr 80 -> word load 0xF0F0F0F0.
- Word load at addr 20 after the byte store in the first scenario -> 0x00F00000 (other lanes remain reset 0).
- Word store 0x12345678 at addr 4 -> mem1 = 0x12345678. Byte store 0xAB at addr 5 -> mem1 = 0x1234AB78.
- Assert rstn mid-ACCESS of a word store to addr 4 -> store does not commit. Memory, mem1, mem_read_data and stall = 0 immediately.

Source files
------------

// File: rtl/data_memory_controller_pkg.sv
// Shared definitions for the MEM-stage data memory controller.
//   LS_BYTE / LS_HALF / LS_WORD : access size codes. The values match the
//                                 existing controls.sv defines.
//   state_t                     : two-state access FSM encoding.
//   lane_enable()               : byte lanes touched by a store.
//   replicate_store()           : store data copied onto every lane it may hit.
package data_memory_controller_pkg;

    localparam logic [1:0] LS_BYTE = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Type 2'b11 falls into the default branch, so it behaves as a word access.
    function automatic logic [3:0] lane_enable(input logic [1:0] ls_type,
                                               input logic [1:0] offset);
        case (ls_type)
            LS_BYTE: return 4'b0001 << offset;
            LS_HALF: return offset[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // The data is replicated across lanes, so the lane enable alone decides
    // which bytes land. This avoids a shifter on the store path.
    function automatic logic [31:0] replicate_store(input logic [1:0]  ls_type,
                                                    input logic [31:0] data);
        case (ls_type)
            LS_BYTE: return {4{data[7:0]}};
            LS_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_controller_load_extender.sv
// Combinational load formatter. It picks the addressed byte or halfword out of
// a raw little-endian memory word and sign- or zero-extends it to 32 bits.
//   raw_word    in  32 : word as read from memory
//   offset      in  2  : byte offset (mem_addr[1:0])
//   ls_type     in  2  : LS_BYTE / LS_HALF / LS_WORD (2'b11 acts as word)
//   is_unsigned in  1  : 1 = zero-extend, 0 = sign-extend
//   result      out 32 : extended load value
module load_extender
    import data_memory_controller_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [1:0]  offset,
    input  logic [1:0]  ls_type,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw_word[7:0];
        case (offset)
            2'd0: byte_sel = raw_word[7:0];
            2'd1: byte_sel = raw_word[15:8];
            2'd2: byte_sel = raw_word[23:16];
            2'd3: byte_sel = raw_word[31:24];
            default: byte_sel = raw_word[7:0];
        endcase
        // A halfword is selected by offset bit 1 only; bit 0 is ignored.
        half_sel = offset[1] ? raw_word[31:16] : raw_word[15:0];
    end

    always_comb begin
        result = raw_word;
        case (ls_type)
            LS_BYTE: result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            LS_HALF: result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default: result = raw_word;
        endcase
    end

endmodule

// File: rtl/data_memory_controller.sv
// Byte-addressable data memory with a two-cycle load/store controller for the
// MEM stage. A request raises stall during its first (IDLE) cycle. On the edge
// that ends the following ACCESS cycle, a store is committed or the addressed
// word is latched. The latched word is formatted combinationally from the
// current offset, type and signedness.
//   clk             in  1          : clock, rising edge
//   rstn            in  1          : asynchronous reset, active HIGH
//   mem_addr        in  ADDR_WIDTH : byte address (wraps modulo NUM_MEM_BYTES)
//   mem_write_data  in  DATA_WIDTH : store data
//   mem_read        in  1          : load request
//   mem_write       in  1          : store request (wins over mem_read)
//   load_store_type in  2          : LS_BYTE / LS_HALF / LS_WORD
//   load_unsigned   in  1          : zero-extend loads when 1
//   mem_read_data   out DATA_WIDTH : extended load result
//   mem1            out 32         : live view of memory word 1 (bytes 4..7)
//   stall           out 1          : pipeline freeze request
module data_memory_controller
    import data_memory_controller_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_MEM_BYTES = 256
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            load_store_type,
    input  logic                  load_unsigned,
    output logic [DATA_WIDTH-1:0] mem_read_data,
    output logic [31:0]           mem1,
    output logic                  stall
);

    localparam int IDX_W      = $clog2(NUM_MEM_BYTES);
    localparam int NUM_WORDS  = NUM_MEM_BYTES / 4;
    localparam int WORD_IDX_W = IDX_W - 2;

    state_t                state_reg, state_next;
    logic [31:0]           mem_reg [NUM_WORDS];
    logic [31:0]           raw_word_reg;

    logic [WORD_IDX_W-1:0] word_idx;
    logic [1:0]            offset;
    logic                  request;
    logic                  stall_next;
    logic                  commit_write;
    logic                  commit_read;
    logic [3:0]            lane_en;
    logic [31:0]           store_data;
    logic [NUM_WORDS-1:0]  word_we;
    logic                  addr_unused;

    assign word_idx    = mem_addr[IDX_W-1:2];
    assign offset      = mem_addr[1:0];
    assign request     = mem_read | mem_write;
    assign lane_en     = lane_enable(load_store_type, offset);
    assign store_data  = replicate_store(load_store_type, mem_write_data[31:0]);
    // Address bits above the memory size are ignored, so accesses wrap.
    assign addr_unused = ^mem_addr[ADDR_WIDTH-1:IDX_W];

    always_comb begin
        state_next   = state_reg;
        stall_next   = 1'b0;
        commit_write = 1'b0;
        commit_read  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (request) begin
                    stall_next = 1'b1;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // The request must still be present here. If it was dropped,
                // the access is abandoned without side effects.
                state_next   = ST_IDLE;
                commit_write = mem_write;
                commit_read  = mem_read & ~mem_write;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Reset is asynchronous, so mask stall as soon as reset is asserted. A
    // request that is still high must not freeze the pipeline during reset.
    assign stall = stall_next & ~rstn;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word_we
        assign word_we[gi] = commit_write && (word_idx == WORD_IDX_W'(gi));
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                mem_reg[w] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                for (int l = 0; l < 4; l++) begin
                    if (word_we[w] && lane_en[l]) begin
                        mem_reg[w][8*l +: 8] <= store_data[8*l +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            raw_word_reg <= '0;
        end else if (commit_read) begin
            raw_word_reg <= mem_reg[word_idx];
        end
    end

    assign mem1 = mem_reg[1];

    load_extender u_load_extender (
        .raw_word    (raw_word_reg),
        .offset      (offset),
        .ls_type     (load_store_type),
        .is_unsigned (load_unsigned),
        .result      (mem_read_data)
    );

endmodule

// File: tb/tb_data_memory_controller.sv
// Self-checking bench for data_memory_controller. The reference model is a
// plain byte array plus the four bytes captured by the last completed load.
module tb_data_memory_controller;

    localparam int NBYTES = 256;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  load_store_type;
    logic        load_unsigned;
    logic [31:0] mem_read_data;
    logic [31:0] mem1;
    logic        stall;

    int total = 0;
    int bad   = 0;

    byte unsigned model_mem [NBYTES];
    byte unsigned model_raw [4];

    data_memory_controller #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .NUM_MEM_BYTES (NBYTES)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .mem_addr        (mem_addr),
        .mem_write_data  (mem_write_data),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .load_store_type (load_store_type),
        .load_unsigned   (load_unsigned),
        .mem_read_data   (mem_read_data),
        .mem1            (mem1),
        .stall           (stall)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NBYTES; i++) model_mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) model_raw[i] = 8'h00;
    endfunction

    function automatic void model_store(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [1:0] t);
        int a;
        a = int'(addr % NBYTES);
        if (t == 2'd0) begin
            model_mem[a] = data[7:0];
        end else if (t == 2'd1) begin
            a = a - (a % 2);
            model_mem[a]     = data[7:0];
            model_mem[a + 1] = data[15:8];
        end else begin
            a = a - (a % 4);
            for (int i = 0; i < 4; i++) model_mem[a + i] = byte'(data >> (8 * i));
        end
    endfunction

    function automatic void model_load(input logic [31:0] addr);
        int a;
        a = int'(addr % NBYTES);
        a = a - (a % 4);
        for (int i = 0; i < 4; i++) model_raw[i] = model_mem[a + i];
    endfunction

    function automatic logic [31:0] model_word(input int base);
        return model_mem[base] + 256 * model_mem[base + 1]
             + 65536 * model_mem[base + 2] + 16777216 * model_mem[base + 3];
    endfunction

    function automatic logic [31:0] model_result(input logic [31:0] addr, input logic [1:0] t,
                                                 input logic uns);
        int off;
        logic [31:0] v;
        off = int'(addr % 4);
        if (t == 2'd0) begin
            v = model_raw[off];
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (t == 2'd1) begin
            off = off - (off % 2);
            v = model_raw[off] + 256 * model_raw[off + 1];
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = model_raw[0] + 256 * model_raw[1] + 65536 * model_raw[2]
              + 16777216 * model_raw[3];
        end
        return v;
    endfunction

    // One access: request is raised on a falling edge, optionally dropped
    // during the ACCESS cycle (abort), and released after the commit edge.
    task automatic run_access(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] data, input logic [1:0] t,
                              input bit uns, input bit abort_it);
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_addr = addr;
        mem_write_data = data; load_store_type = t; load_unsigned = uns;
        #1 check_val("stall_first", {31'd0, stall}, {31'd0, rd | wr});
        @(negedge clk);
        if (abort_it) begin
            mem_read = 1'b0; mem_write = 1'b0;
        end
        #1 check_val("stall_second", {31'd0, stall}, 32'd0);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        if (!abort_it) begin
            if (wr) model_store(addr, data, t);
            else if (rd) model_load(addr);
        end
        #1;
        check_val("mem1", mem1, model_word(4));
        check_val("read_data", mem_read_data, model_result(addr, t, uns));
        $display("txn rd=%0b wr=%0b abort=%0b addr=%08h data=%08h type=%0d uns=%0b rdata=%08h mem1=%08h",
                 rd, wr, abort_it, addr, data, t, uns, mem_read_data, mem1);
    endtask

    initial begin
        rstn = 1'b1; mem_addr = '0; mem_write_data = '0; mem_read = 1'b0;
        mem_write = 1'b0; load_store_type = 2'b10; load_unsigned = 1'b0;
        model_reset();
        #1;
        check_val("rst_rdata", mem_read_data, 32'd0);
        check_val("rst_mem1", mem1, 32'd0);
        check_val("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b0;

        // Byte store then signed and unsigned byte load at 22.
        run_access(0, 1, 32'd22, 32'hF0F0_F0F0, 2'b00, 0, 0);
        run_access(1, 0, 32'd22, 32'h0, 2'b00, 0, 0);
        check_val("byte_signed", mem_read_data, 32'hFFFF_FFF0);
        load_unsigned = 1'b1;
        #1 check_val("byte_unsigned", mem_read_data, 32'h0000_00F0);

        // Halfword store and loads at 150.
        run_access(0, 1, 32'd150, 32'hF0F0_F0F0, 2'b01, 0, 0);
        run_access(1, 0, 32'd150, 32'h0, 2'b01, 0, 0);
        check_val("half_signed", mem_read_data, 32'hFFFF_F0F0);
        load_unsigned = 1'b1;
        #1 check_val("half_unsigned", mem_read_data, 32'h0000_F0F0);

        // Word store and load at 80, then a word load at 20 that includes byte 22.
        run_access(0, 1, 32'd80, 32'hF0F0_F0F0, 2'b10, 0, 0);
        run_access(1, 0, 32'd80, 32'h0, 2'b10, 0, 0);
        check_val("word_80", mem_read_data, 32'hF0F0_F0F0);
        run_access(1, 0, 32'd20, 32'h0, 2'b10, 1, 0);
        check_val("word_20", mem_read_data, 32'h00F0_0000);

        // Debug word 1.
        run_access(0, 1, 32'd4, 32'h1234_5678, 2'b10, 0, 0);
        check_val("mem1_word", mem1, 32'h1234_5678);
        run_access(0, 1, 32'd5, 32'h0000_00AB, 2'b00, 0, 0);
        check_val("mem1_byte", mem1, 32'h1234_AB78);

        // Randomized mix of loads, stores, simultaneous requests, aborts, wrap.
        for (int n = 0; n < 300; n++) begin
            int kind;
            bit rd, wr, ab;
            logic [31:0] addr;
            kind = int'($urandom_range(0, 9));
            rd = (kind <= 3) || (kind == 8);
            wr = (kind >= 4 && kind <= 8);
            ab = ($urandom_range(0, 7) == 0);
            addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31));
            run_access(rd, wr, addr, $urandom, 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), ab);
        end

        // Reset asserted in the middle of a word store to address 4.
        @(negedge clk);
        mem_write = 1'b1; mem_addr = 32'd4; mem_write_data = 32'hDEAD_BEEF;
        load_store_type = 2'b10;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        #1;
        check_val("midrst_mem1", mem1, 32'd0);
        check_val("midrst_stall", {31'd0, stall}, 32'd0);
        check_val("midrst_rdata", mem_read_data, 32'd0);
        @(negedge clk);
        mem_write = 1'b0;
        rstn = 1'b0;
        #1 check_val("postrst_mem1", mem1, 32'd0);
        run_access(1, 0, 32'd4, 32'h0, 2'b10, 0, 0);
        check_val("postrst_word4", mem_read_data, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
